// File: rtl/apb_mem_slave_v2.sv
// APB4 scratch RAM with byte strobes, fixed wait states and registered response.
// Optional privileged top quarter when APB_SLV_PROT_CHECK_EN is defined.
module apb_mem_slave_v2 #(
  parameter int ADDR_SIZE   = 32,
  parameter int MEM_WIDTH   = 32,
  parameter int MEM_DEPTH   = 64,
  parameter int WAIT_CYCLES = 0,
  parameter int PROT_SIZE   = 3
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   SSELX,
  input  logic                   SENABLE,
  input  logic                   SWRITE,
  input  logic [PROT_SIZE-1:0]   SPROT,
  input  logic [MEM_WIDTH/8-1:0] SSTRB,
  input  logic [ADDR_SIZE-1:0]   SADDR,
  input  logic [MEM_WIDTH-1:0]   SWDATA,
  output logic                   SREADY,
  output logic                   SSLVERR,
  output logic [MEM_WIDTH-1:0]   SRDATA
);

  localparam int STRB_SIZE = MEM_WIDTH / 8;
  localparam int LSB       = (STRB_SIZE > 1) ? $clog2(STRB_SIZE) : 0;
  localparam int IW        = $clog2(MEM_DEPTH);
  localparam int PRIV_BASE = MEM_DEPTH - MEM_DEPTH / 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 err_q, err_d;
  logic                 wr_q, wr_d;
  logic                 ready_q, ready_d;
  logic                 slverr_q, slverr_d;
  logic [MEM_WIDTH-1:0] rdata_q, rdata_d;

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  logic [IW-1:0] idx_in;
  logic          oor;
  logic          mis;
  logic          priv;
  logic          err_in;

  assign idx_in = SADDR[LSB +: IW];
  assign oor    = |SADDR[ADDR_SIZE-1:LSB+IW];

  generate
    if (LSB > 0) begin : g_align
      assign mis = |SADDR[LSB-1:0];
    end else begin : g_noalign
      assign mis = 1'b0;
    end
  endgenerate

`ifdef APB_SLV_PROT_CHECK_EN
  assign priv = (idx_in >= IW'(PRIV_BASE)) && !SPROT[0];
`else
  logic unused_prot;
  assign unused_prot = ^SPROT;
  assign priv        = 1'b0;
`endif

  assign err_in = oor | mis | priv | (!SWRITE && |SSTRB);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    err_d    = err_q;
    wr_d     = wr_q;
    ready_d  = 1'b0;
    slverr_d = 1'b0;
    rdata_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (SSELX && SENABLE) begin
          idx_d = idx_in;
          err_d = err_in;
          wr_d  = SWRITE;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end else begin
            state_d  = S_RESP;
            ready_d  = 1'b1;
            slverr_d = err_in;
            if (!SWRITE && !err_in) rdata_d = mem[idx_in];
          end
        end
      end
      S_WAIT: begin
        if (!SSELX) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d  = S_RESP;
          cnt_d    = '0;
          ready_d  = 1'b1;
          slverr_d = err_q;
          if (!wr_q && !err_q) rdata_d = mem[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      wr_q     <= 1'b0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      wr_q     <= wr_d;
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
      rdata_q  <= rdata_d;
    end
  end

  // Commit on the edge that closes RESP; reset at that edge cancels it
  always_ff @(posedge PCLK) begin
    if (PRESETn && state_q == S_RESP && wr_q && SWRITE && !err_q) begin
      for (int i = 0; i < STRB_SIZE; i++) begin
        if (SSTRB[i]) mem[idx_q][8*i +: 8] <= SWDATA[8*i +: 8];
      end
    end
  end

  assign SREADY  = ready_q;
  assign SSLVERR = slverr_q;
  assign SRDATA  = rdata_q;

endmodule

// File: tb/tb_apb_mem_slave_v2.sv
// Bench for apb_mem_slave_v2: DUT 0 has no wait states, DUT 1 has three.
// Random and directed APB transfers are checked against a word-array model.
module tb_apb_mem_slave_v2;

`ifdef APB_SLV_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn [2];
  logic        ssel [2];
  logic        en   [2];
  logic        wr   [2];
  logic [2:0]  prot [2];
  logic [3:0]  strb [2];
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic        rdy  [2];
  logic        serr [2];
  logic [31:0] rdat [2];

  logic [31:0] mdl [2][64];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_mem_slave_v2 #(.WAIT_CYCLES(0)) u_dut0 (
    .PCLK(clk), .PRESETn(rstn[0]), .SSELX(ssel[0]), .SENABLE(en[0]),
    .SWRITE(wr[0]), .SPROT(prot[0]), .SSTRB(strb[0]), .SADDR(addr[0]),
    .SWDATA(wdat[0]), .SREADY(rdy[0]), .SSLVERR(serr[0]), .SRDATA(rdat[0])
  );

  apb_mem_slave_v2 #(.WAIT_CYCLES(3)) u_dut1 (
    .PCLK(clk), .PRESETn(rstn[1]), .SSELX(ssel[1]), .SENABLE(en[1]),
    .SWRITE(wr[1]), .SPROT(prot[1]), .SSTRB(strb[1]), .SADDR(addr[1]),
    .SWDATA(wdat[1]), .SREADY(rdy[1]), .SSLVERR(serr[1]), .SRDATA(rdat[1])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic exp_err(input logic w, input logic [31:0] a,
                                   input logic [3:0] s, input logic [2:0] p);
    logic e;
    e = (a / 4 >= 64) || (a % 4 != 0) || (!w && s != 0);
    if (PROT_EN && a / 4 >= 48 && a / 4 < 64 && !p[0]) e = 1'b1;
    return e;
  endfunction

  task automatic setup(input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] wd,
                       input logic [2:0] p);
    @(posedge clk); #1;
    ssel[d] = 1'b1; en[d] = 1'b0; wr[d] = w;
    addr[d] = a; strb[d] = s; wdat[d] = wd; prot[d] = p;
    @(posedge clk); #1;
    en[d] = 1'b1;
  endtask

  task automatic apb(input int d, input logic w, input logic [31:0] a,
                     input logic [3:0] s, input logic [31:0] wd,
                     input logic [2:0] p, output logic [31:0] rd,
                     output logic er, output int lat);
    setup(d, w, a, s, wd, p);
    lat = 0; rd = '0; er = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rdy[d]) begin
        lat = c; rd = rdat[d]; er = serr[d];
        break;
      end
    end
    @(posedge clk); #1;
    ssel[d] = 1'b0; en[d] = 1'b0;
  endtask

  task automatic xfer(input int d, input string tag, input logic w,
                      input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] wd, input logic [2:0] p,
                      output logic [31:0] rd, output logic er);
    logic [31:0] erd, mask;
    logic        ee;
    int          lat;
    ee  = exp_err(w, a, s, p);
    erd = (w || ee) ? 32'h0 : mdl[d][a / 4];
    apb(d, w, a, s, wd, p, rd, er, lat);
    chk({tag, "_lat"}, lat, (d == 0) ? 2 : 5);
    chk({tag, "_err"}, {31'h0, er}, {31'h0, ee});
    chk({tag, "_rdata"}, rd, erd);
    @(negedge clk);
    chk({tag, "_rdy_low"}, {31'h0, rdy[d]}, 32'h0);
    if (w && !ee) begin
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      mdl[d][a / 4] = (mdl[d][a / 4] & ~mask) | (wd & mask);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a;
    logic        er, w;
    logic [3:0]  s;
    int          d, n, r;
    for (int i = 0; i < 2; i++) begin
      rstn[i] = 1'b0; ssel[i] = 1'b0; en[i] = 1'b0; wr[i] = 1'b0;
      prot[i] = '0; strb[i] = '0; addr[i] = '0; wdat[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", {31'h0, rdy[i]}, 32'h0);
      chk("rst_slverr", {31'h0, serr[i]}, 32'h0);
      chk("rst_rdata", rdat[i], 32'h0);
    end
    rstn[0] = 1'b1; rstn[1] = 1'b1;

    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 64; k++)
        xfer(i, "init", 1'b1, 32'(k * 4), 4'hF, $urandom, 3'b001, rd, er);

    xfer(0, "t1_wr", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 3'b001, rd, er);
    xfer(0, "t1_rd", 1'b0, 32'h10, 4'h0, 32'h0, 3'b001, rd, er);
    chk("t1_val", rd, 32'hDEADBEEF);

    xfer(0, "t2_w1", 1'b1, 32'h08, 4'hF, 32'h11223344, 3'b001, rd, er);
    xfer(0, "t2_w2", 1'b1, 32'h08, 4'h5, 32'hAABBCCDD, 3'b001, rd, er);
    xfer(0, "t2_rd", 1'b0, 32'h08, 4'h0, 32'h0, 3'b001, rd, er);
    chk("t2_val", rd, 32'h11BB33DD);

    xfer(0, "t3_oor", 1'b1, 32'h100, 4'hF, 32'h12345678, 3'b001, rd, er);
    chk("t3_oor_flag", {31'h0, er}, 32'h1);
    xfer(0, "t3_mis", 1'b1, 32'h0A, 4'hF, 32'h55555555, 3'b001, rd, er);
    chk("t3_mis_flag", {31'h0, er}, 32'h1);
    xfer(0, "t3_keep", 1'b0, 32'h08, 4'h0, 32'h0, 3'b001, rd, er);
    chk("t3_keep_val", rd, 32'h11BB33DD);
    xfer(0, "t3_rstrb", 1'b0, 32'h10, 4'h1, 32'h0, 3'b001, rd, er);
    chk("t3_rstrb_flag", {31'h0, er}, 32'h1);

    xfer(1, "t4_rd", 1'b0, 32'h10, 4'h0, 32'h0, 3'b001, rd, er);
    setup(1, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D, 3'b001);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ssel[1] = 1'b0; en[1] = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (rdy[1]) n++;
    end
    chk("t4_abort_rdy", n, 0);
    xfer(1, "t4_after", 1'b0, 32'h30, 4'h0, 32'h0, 3'b001, rd, er);

    setup(1, 1'b1, 32'h20, 4'hF, 32'h0BADF00D, 3'b001);
    @(posedge clk); #1;
    rstn[1] = 1'b0; ssel[1] = 1'b0; en[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_rdy", {31'h0, rdy[1]}, 32'h0);
    chk("t5_serr", {31'h0, serr[1]}, 32'h0);
    chk("t5_rdata", rdat[1], 32'h0);
    #1 rstn[1] = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy[1]) n++;
    end
    chk("t5_no_resp", n, 0);
    xfer(1, "t5_rd", 1'b0, 32'h20, 4'h0, 32'h0, 3'b001, rd, er);

    xfer(0, "t6_w0", 1'b1, 32'hC8, 4'hF, 32'h600DCAFE, 3'b000, rd, er);
    chk("t6_w0_flag", {31'h0, er}, {31'h0, PROT_EN});
    xfer(0, "t6_r0", 1'b0, 32'hC8, 4'h0, 32'h0, 3'b001, rd, er);
    xfer(0, "t6_w1", 1'b1, 32'hC8, 4'hF, 32'h13572468, 3'b001, rd, er);
    chk("t6_w1_flag", {31'h0, er}, 32'h0);
    xfer(0, "t6_r1", 1'b0, 32'hC8, 4'h0, 32'h0, 3'b001, rd, er);
    chk("t6_r1_val", rd, 32'h13572468);

    for (int it = 0; it < 300; it++) begin
      d = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, 63) * 4);
      else if (r == 7) a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      else if (r == 8) a = 32'h100 + 32'($urandom_range(0, 255) * 4);
      else             a = $urandom;
      w = 1'($urandom_range(0, 1));
      s = 4'($urandom);
      if (!w && $urandom_range(0, 4) != 0) s = 4'h0;
      xfer(d, "rnd", w, a, s, $urandom, 3'($urandom), rd, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
